// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO direction sequencer.
//   - default pad count, turnaround length and synchroniser depth
//   - sequencer state encoding (IDLE / TURN)
package gpio_pkg;

  localparam int GPIO_WIDTH       = 32;
  localparam int GPIO_TURN_CYC    = 2;
  localparam int GPIO_SYNC_STAGES = 2;

  typedef enum logic {
    GPIO_SEQ_IDLE = 1'b0,
    GPIO_SEQ_TURN = 1'b1
  } gpio_seq_state_e;

endpackage

// File: rtl/gpio_dir_sequencer_if.sv
// Configuration handshake between the GPIO register block (master) and the
// direction sequencer (slave).
//   cfg_valid  master->slave  new config offered
//   cfg_ready  slave->master  config taken when valid & ready at a clock edge
//   cfg_oen    master->slave  requested direction per pad (1 = output)
//   cfg_out    master->slave  requested output data per pad
interface gpio_dir_sequencer_if #(
  parameter int WIDTH = 32
) ();

  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_oen;
  logic [WIDTH-1:0] cfg_out;

  modport master (output cfg_valid, output cfg_oen, output cfg_out, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_oen, input cfg_out, output cfg_ready);

endinterface

// File: rtl/gpio_in_sync.sv
// Multi-stage synchroniser for asynchronous pad read-back.
//   clk   in   clock of the destination domain
//   rst   in   synchronous, active-high reset (clears every stage)
//   d     in   raw asynchronous pad levels
//   hold  in   per-bit freeze: a set bit keeps its whole chain unchanged
//   q     out  synchronised levels (last stage)
module gpio_in_sync #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] hold,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  // NOTE: every flop here is assigned with <= so all stages sample the
  // pre-edge value of their neighbour; a blocking '=' would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the stage array is a chain of flops, not a RAM, so clearing it
      // in a loop on reset is cheap and keeps read-back deterministic.
      for (int i = 0; i < STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= (stage[0] & hold) | (d & ~hold);
      for (int i = 1; i < STAGES; i++) begin
        stage[i] <= (stage[i] & hold) | (stage[i-1] & ~hold);
      end
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/gpio_dir_sequencer.sv
// Contention-free direction/data sequencer for a bank of GPIO pads.
// Pads turning output->input are released at the accept edge; pads turning
// input->output get their data preloaded at accept and their OE raised
// TURN_CYC edges later. Pad read-back is synchronised into pclk.
//   pclk         in   clock
//   preset       in   synchronous, active-high reset
//   cfg_bus      slave handshake: cfg_valid/cfg_ready/cfg_oen/cfg_out
//   out_pad_o    out  data to pad tri-state buffers
//   oen_padoe_o  out  output enable to pad buffers (1 = drive)
//   in_pad_i     in   raw asynchronous pad read-back
//   in_sync_o    out  synchronised pad read-back
//   busy_o       out  a direction change is in progress
module gpio_dir_sequencer
  import gpio_pkg::*;
#(
  parameter int WIDTH       = GPIO_WIDTH,
  parameter int TURN_CYC    = GPIO_TURN_CYC,    // 1..15
  parameter int SYNC_STAGES = GPIO_SYNC_STAGES  // >= 2
) (
  input  logic                 pclk,
  input  logic                 preset,
  gpio_dir_sequencer_if.slave  cfg_bus,
  output logic [WIDTH-1:0]     out_pad_o,
  output logic [WIDTH-1:0]     oen_padoe_o,
  input  logic [WIDTH-1:0]     in_pad_i,
  output logic [WIDTH-1:0]     in_sync_o,
  output logic                 busy_o
);

  gpio_seq_state_e  state, next_state;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] lat_oen;
  logic [WIDTH-1:0] lat_out;
  logic [WIDTH-1:0] hold_mask;

  logic             accept;
  logic             swap;
  logic             last_turn;
  logic [WIDTH-1:0] rel;
  logic [WIDTH-1:0] acq;
  logic [WIDTH-1:0] sync_hold;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    cfg_bus.cfg_ready = (state == GPIO_SEQ_IDLE);
    busy_o            = (state != GPIO_SEQ_IDLE);
    accept            = cfg_bus.cfg_valid & cfg_bus.cfg_ready;
    rel               = oen_padoe_o & ~cfg_bus.cfg_oen;
    acq               = ~oen_padoe_o & cfg_bus.cfg_oen;
    swap              = |(rel | acq);
    last_turn         = (cnt == 4'd1);
    sync_hold         = (state == GPIO_SEQ_TURN) ? hold_mask : '0;
    next_state        = state;
    unique case (state)
      GPIO_SEQ_IDLE: if (accept && swap) next_state = GPIO_SEQ_TURN;
      GPIO_SEQ_TURN: if (last_turn)      next_state = GPIO_SEQ_IDLE;
      default:                           next_state = GPIO_SEQ_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) state <= GPIO_SEQ_IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      out_pad_o   <= '0;
      oen_padoe_o <= '0;
      lat_oen     <= '0;
      lat_out     <= '0;
      hold_mask   <= '0;
      cnt         <= '0;
    end else begin
      unique case (state)
        GPIO_SEQ_IDLE: begin
          if (accept) begin
            if (swap) begin
              lat_oen     <= cfg_bus.cfg_oen;
              lat_out     <= cfg_bus.cfg_out;
              hold_mask   <= rel | acq;
              // Released pads keep their old data until OE is off; acquired
              // pads are preloaded now so data is stable before OE rises.
              out_pad_o   <= (cfg_bus.cfg_out & ~rel) | (out_pad_o & rel);
              oen_padoe_o <= oen_padoe_o & ~rel;
              cnt         <= 4'(TURN_CYC);
            end else begin
              out_pad_o   <= cfg_bus.cfg_out;
            end
          end
        end
        GPIO_SEQ_TURN: begin
          cnt <= cnt - 4'd1;
          if (last_turn) begin
            oen_padoe_o <= lat_oen;
            out_pad_o   <= lat_out;
          end
        end
        default: ;
      endcase
    end
  end

  gpio_in_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_in_sync (
    .clk  (pclk),
    .rst  (preset),
    .d    (in_pad_i),
    .hold (sync_hold),
    .q    (in_sync_o)
  );

endmodule

// File: tb/tb_gpio_dir_sequencer.sv
module tb_gpio_dir_sequencer;

  localparam int W  = 32;
  localparam int TC = 2;
  localparam int SS = 2;

  logic         pclk;
  logic         preset;
  logic [W-1:0] out_pad_o;
  logic [W-1:0] oen_padoe_o;
  logic [W-1:0] in_pad_i;
  logic [W-1:0] in_sync_o;
  logic         busy_o;

  gpio_dir_sequencer_if #(.WIDTH(W)) cfg_bus ();

  gpio_dir_sequencer #(
    .WIDTH       (W),
    .TURN_CYC    (TC),
    .SYNC_STAGES (SS)
  ) dut (
    .pclk        (pclk),
    .preset      (preset),
    .cfg_bus     (cfg_bus),
    .out_pad_o   (out_pad_o),
    .oen_padoe_o (oen_padoe_o),
    .in_pad_i    (in_pad_i),
    .in_sync_o   (in_sync_o),
    .busy_o      (busy_o)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a pending config is applied at an absolute cycle
  // number (accept cycle + TC); read-back bits travel through SS samples
  // unless frozen while their pad is part of a pending direction change.
  int           m_cyc = 0;
  bit           m_pending = 0;
  int           m_apply_at = 0;
  logic [W-1:0] m_oen = '0, m_out = '0;
  logic [W-1:0] m_new_oen = '0, m_new_out = '0, m_mask = '0;
  logic [W-1:0] m_pipe [SS];

  initial for (int s = 0; s < SS; s++) m_pipe[s] = '0;

  always @(posedge pclk) begin
    logic [W-1:0] held, rel, acq;
    held = m_pending ? m_mask : '0;
    if (preset) begin
      m_pending = 0;
      m_oen = '0;
      m_out = '0;
      for (int s = 0; s < SS; s++) m_pipe[s] = '0;
    end else begin
      for (int s = SS - 1; s >= 0; s--)
        for (int b = 0; b < W; b++)
          if (!held[b]) m_pipe[s][b] = (s == 0) ? in_pad_i[b] : m_pipe[s-1][b];
      if (m_pending) begin
        if (m_cyc == m_apply_at) begin
          m_oen = m_new_oen;
          m_out = m_new_out;
          m_pending = 0;
        end
      end else if (cfg_bus.cfg_valid) begin
        rel = m_oen & ~cfg_bus.cfg_oen;
        acq = ~m_oen & cfg_bus.cfg_oen;
        if ((rel | acq) == '0) begin
          m_out = cfg_bus.cfg_out;
        end else begin
          m_new_oen  = cfg_bus.cfg_oen;
          m_new_out  = cfg_bus.cfg_out;
          m_mask     = rel | acq;
          m_pending  = 1;
          m_apply_at = m_cyc + TC;
          m_out      = (cfg_bus.cfg_out & ~rel) | (m_out & rel);
          m_oen      = m_oen & ~rel;
        end
      end
    end
    m_cyc++;
  end

  bit compare_on = 0;
  always @(posedge pclk) begin
    #1;
    if (compare_on) begin
      check("cyc_oen",   oen_padoe_o, m_oen);
      check("cyc_out",   out_pad_o, m_out);
      check("cyc_busy",  W'(busy_o), W'(m_pending));
      check("cyc_ready", W'(cfg_bus.cfg_ready), W'(!m_pending));
      check("cyc_sync",  in_sync_o, m_pipe[SS-1]);
    end
  end

  // Offer a config at a negedge and hold it until the edge that takes it.
  task automatic offer(input logic [W-1:0] o, input logic [W-1:0] d);
    bit taken = 0;
    cfg_bus.cfg_oen   = o;
    cfg_bus.cfg_out   = d;
    cfg_bus.cfg_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (cfg_bus.cfg_ready) begin
        @(negedge pclk);
        taken = 1;
        break;
      end
      @(negedge pclk);
    end
    cfg_bus.cfg_valid = 1'b0;
    if (!taken) check("offer_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit idle = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy_o) begin
        idle = 1;
        break;
      end
      @(negedge pclk);
    end
    if (!idle) check("idle_timeout", 0, 1);
  endtask

  initial begin
    preset            = 1'b1;
    in_pad_i          = '0;
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_oen   = '0;
    cfg_bus.cfg_out   = '0;
    compare_on        = 1;
    repeat (3) @(negedge pclk);

    // Reset state
    check("rst_oen",   oen_padoe_o, '0);
    check("rst_out",   out_pad_o, '0);
    check("rst_busy",  W'(busy_o), 0);
    check("rst_ready", W'(cfg_bus.cfg_ready), 1);
    check("rst_sync",  in_sync_o, '0);
    preset = 1'b0;
    @(negedge pclk);

    // Data-only update
    offer(32'h0000_00FF, 32'h0);
    wait_idle();
    check("pre_oen_ff", oen_padoe_o, 32'h0000_00FF);
    cfg_bus.cfg_oen   = 32'h0000_00FF;
    cfg_bus.cfg_out   = 32'h0000_00A5;
    cfg_bus.cfg_valid = 1'b1;
    @(negedge pclk);
    cfg_bus.cfg_valid = 1'b0;
    check("data_out",  out_pad_o, 32'h0000_00A5);
    check("data_busy", W'(busy_o), 0);
    check("data_oen",  oen_padoe_o, 32'h0000_00FF);

    // Direction swap
    offer(32'h0000_000F, 32'h0);
    wait_idle();
    check("pre_oen_0f", oen_padoe_o, 32'h0000_000F);
    check("pre_out_0",  out_pad_o, 32'h0);
    cfg_bus.cfg_oen   = 32'h0000_00F0;
    cfg_bus.cfg_out   = 32'h0000_0050;
    cfg_bus.cfg_valid = 1'b1;
    @(negedge pclk);
    cfg_bus.cfg_valid = 1'b0;
    check("swap_acc_oen",  oen_padoe_o, 32'h0);
    check("swap_acc_out",  out_pad_o, 32'h0000_0050);
    check("swap_acc_busy", W'(busy_o), 1);
    @(negedge pclk);
    check("swap_t1_oen",  oen_padoe_o, 32'h0);
    check("swap_t1_busy", W'(busy_o), 1);
    @(negedge pclk);
    check("swap_t2_oen",  oen_padoe_o, 32'h0000_00F0);
    check("swap_t2_out",  out_pad_o, 32'h0000_0050);
    check("swap_t2_busy", W'(busy_o), 0);

    // Backpressure: second config held during TURN
    cfg_bus.cfg_oen   = 32'h0000_000F;
    cfg_bus.cfg_out   = 32'h0000_000A;
    cfg_bus.cfg_valid = 1'b1;
    @(negedge pclk);
    cfg_bus.cfg_out   = 32'h0000_0003;
    check("bp_t0_ready", W'(cfg_bus.cfg_ready), 0);
    check("bp_t0_out",   out_pad_o, 32'h0000_005A);
    check("bp_t0_oen",   oen_padoe_o, 32'h0);
    @(negedge pclk);
    check("bp_t1_ready", W'(cfg_bus.cfg_ready), 0);
    check("bp_t1_out",   out_pad_o, 32'h0000_005A);
    @(negedge pclk);
    check("bp_apply_oen", oen_padoe_o, 32'h0000_000F);
    check("bp_apply_out", out_pad_o, 32'h0000_000A);
    check("bp_ready",     W'(cfg_bus.cfg_ready), 1);
    @(negedge pclk);
    cfg_bus.cfg_valid = 1'b0;
    check("bp_second_out",  out_pad_o, 32'h0000_0003);
    check("bp_second_busy", W'(busy_o), 0);

    // Reset in the middle of TURN
    cfg_bus.cfg_oen   = 32'h0000_FF00;
    cfg_bus.cfg_out   = 32'h0000_1234;
    cfg_bus.cfg_valid = 1'b1;
    @(negedge pclk);
    cfg_bus.cfg_valid = 1'b0;
    check("mid_busy", W'(busy_o), 1);
    preset = 1'b1;
    @(negedge pclk);
    preset = 1'b0;
    check("mid_rst_oen",   oen_padoe_o, '0);
    check("mid_rst_out",   out_pad_o, '0);
    check("mid_rst_busy",  W'(busy_o), 0);
    check("mid_rst_ready", W'(cfg_bus.cfg_ready), 1);
    repeat (4) @(negedge pclk);
    check("mid_dropped_oen", oen_padoe_o, '0);
    check("mid_dropped_out", out_pad_o, '0);

    // Read-back synchronisation and hold
    in_pad_i[3] = 1'b1;
    @(negedge pclk);
    check("sync_e1", W'(in_sync_o[3]), 0);
    @(negedge pclk);
    check("sync_e2", W'(in_sync_o[3]), 1);
    offer(32'h0000_0008, 32'h0);
    wait_idle();
    check("sync_pre_oen", oen_padoe_o, 32'h0000_0008);
    in_pad_i[3]       = 1'b0;
    cfg_bus.cfg_oen   = 32'h0;
    cfg_bus.cfg_out   = 32'h0;
    cfg_bus.cfg_valid = 1'b1;
    @(negedge pclk);
    cfg_bus.cfg_valid = 1'b0;
    check("hold_acc", W'(in_sync_o[3]), 1);
    @(negedge pclk);
    check("hold_t1", W'(in_sync_o[3]), 1);
    @(negedge pclk);
    check("hold_t2", W'(in_sync_o[3]), 1);
    @(negedge pclk);
    check("hold_release", W'(in_sync_o[3]), 0);

    // A few unheld bits travelling together
    in_pad_i = 32'hC3C3_0001;
    repeat (SS) @(negedge pclk);
    check("sync_word", in_sync_o, 32'hC3C3_0001);
    repeat (2) @(negedge pclk);

    compare_on = 0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
